// File: rtl/palette_fade_lut.sv
// palette_fade_lut: programmable palette lookup with a 2-stage brightness-scaled pixel path and a frame-synchronous fade FSM.
// Optional index-0 transparency flag enabled by defining PALETTE_TRANSPARENT_EN.
module palette_fade_lut #(
  parameter int INDEX_W    = 4,
  parameter int COLOR_W    = 4,
  parameter int LEVEL_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_valid,
  input  logic [INDEX_W-1:0]   index,
  input  logic                 wr_en,
  input  logic [INDEX_W-1:0]   wr_addr,
  input  logic [3*COLOR_W-1:0] wr_data,
  input  logic                 frame_tick,
  input  logic                 fade_start,
  input  logic                 fade_dir,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 out_valid,
  output logic                 transparent,
  output logic                 fade_busy,
  output logic                 fade_done
);
  localparam int DEPTH = 2**INDEX_W;
  localparam logic [COLOR_W:0] MAX = (COLOR_W+1)'(2**COLOR_W);
  localparam logic [1:0] IDLE = 2'd0, FADE_IN = 2'd1, FADE_OUT = 2'd2;
  logic [3*COLOR_W-1:0] pal [DEPTH];
  logic [3*COLOR_W-1:0] rd;
  logic                 v1;
  logic [COLOR_W:0]     level, lvl_up, lvl_dn;
  logic [1:0]           state;
  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c, input logic [COLOR_W:0] l);
    logic [2*COLOR_W:0] p;
    p = (2*COLOR_W+1)'(c) * (2*COLOR_W+1)'(l);
    return p[2*COLOR_W-1:COLOR_W];
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH; i++) pal[i] <= {COLOR_W'(i), {(2*COLOR_W){1'b0}}};
    else if (wr_en)
      pal[wr_addr] <= wr_data;
  // stage 1 reads before the same-edge write lands, giving read-before-write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd        <= '0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      rd        <= pal[index];
      v1        <= pix_valid;
      out_valid <= v1;
      if (v1) begin
        red   <= scale(rd[3*COLOR_W-1:2*COLOR_W], level);
        green <= scale(rd[2*COLOR_W-1:COLOR_W], level);
        blue  <= scale(rd[COLOR_W-1:0], level);
      end
    end
  // saturating steps compared before adding/subtracting so no width can wrap
  assign lvl_up = (32'(MAX) - 32'(level) <= 32'(LEVEL_STEP)) ? MAX : level + (COLOR_W+1)'(LEVEL_STEP);
  assign lvl_dn = (32'(level) <= 32'(LEVEL_STEP)) ? '0 : level - (COLOR_W+1)'(LEVEL_STEP);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      level     <= MAX;
      fade_done <= 1'b0;
    end else begin
      fade_done <= 1'b0;
      if (fade_start)
        state <= fade_dir ? FADE_IN : FADE_OUT;
      else if (frame_tick && state == FADE_IN) begin
        level <= lvl_up;
        if (lvl_up == MAX) begin
          state     <= IDLE;
          fade_done <= 1'b1;
        end
      end else if (frame_tick && state == FADE_OUT) begin
        level <= lvl_dn;
        if (lvl_dn == '0) begin
          state     <= IDLE;
          fade_done <= 1'b1;
        end
      end
    end
  assign fade_busy = state != IDLE;
`ifdef PALETTE_TRANSPARENT_EN
  logic z1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      z1          <= 1'b0;
      transparent <= 1'b0;
    end else begin
      z1          <= index == '0;
      transparent <= v1 && z1;
    end
`else
  assign transparent = 1'b0;
`endif
endmodule
